med_ctrl: RTL

Sequencer for the `MED` running-median datapath. It buffers `SIZE` input samples behind a valid/ready handshake and bursts them into `MED` in consecutive cycles. It then drives `MED_DSI`, `MED_BYP` and `MED_DI` through a max-extraction schedule and captures the median from `MED_DO` into a valid/ready output register. It sits between the sample stream and one `MED` instance; `MED` has no enable or reset and shifts every clock, and this block absorbs that constraint.

---
 rtl/med_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/med_ctrl.sv
// Sequencer for one MED running-median datapath: buffers a window of samples,
// bursts them into MED, steps it through max-extraction passes, captures the median.
module med_ctrl #(
    parameter int N    = 7,
    parameter int SIZE = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N:0]   i_s_data,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    output logic [N:0]   o_med_di,
    output logic         o_med_dsi,
    output logic         o_med_byp,
    input  logic [N:0]   i_med_do,
    output logic [N:0]   o_m_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic         o_busy,
    output logic [2:0]   o_dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are
    // both high; the source holds data stable while valid is high and ready is low.

    localparam int CW = $clog2(SIZE + 1);
    localparam int PW = $clog2((SIZE - 1) / 2 + 1);

    localparam logic [CW-1:0] C_FULL     = CW'(SIZE);
    localparam logic [CW-1:0] C_FULL_M1  = CW'(SIZE - 1);
    localparam logic [CW-1:0] C_CMP_LAST = CW'(SIZE - 2);
    localparam logic [PW-1:0] C_PASSES   = PW'((SIZE - 1) / 2);

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_BURST = 3'd1,
        S_CMP   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_k, w_k_nxt;
    logic [PW-1:0] r_pass, w_pass_nxt;
    logic [N:0]    r_buf [SIZE];
    logic          r_med_dsi, r_med_byp;
    logic [N:0]    r_med_di;
    logic [N:0]    r_m_data;
    logic          r_m_valid;

    logic          w_accept;
    logic          w_full_nxt;
    logic          w_capture;
    logic          w_burst_end;
    logic          w_shift_nxt;
    logic [N:0]    w_di_nxt;

    assign o_s_ready   = ~i_rst & (r_cnt < C_FULL) & (r_state != S_BURST);
    assign w_accept    = i_s_valid & o_s_ready;
    assign w_full_nxt  = (r_cnt == C_FULL) | ((r_cnt == C_FULL_M1) & w_accept);
    assign w_capture   = (r_state == S_DONE) & (~r_m_valid | i_m_ready);
    assign w_burst_end = (r_state == S_BURST) & (r_k == C_FULL_M1);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_pass_nxt  = r_pass;
        case (r_state)
            S_FILL: begin
                if (w_full_nxt) begin
                    w_state_nxt = S_BURST;
                    w_k_nxt     = '0;
                end
            end
            S_BURST: begin
                if (w_burst_end) begin
                    w_state_nxt = S_CMP;
                    w_k_nxt     = '0;
                    w_pass_nxt  = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_CMP: begin
                if (r_k == C_CMP_LAST) begin
                    w_state_nxt = (r_pass == C_PASSES) ? S_DONE : S_FLUSH;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_CMP;
                w_k_nxt     = '0;
                w_pass_nxt  = r_pass + 1'b1;
            end
            S_DONE: begin
                // A full buffer would leave FILL on its first cycle, so start its burst now.
                if (w_capture) begin
                    w_state_nxt = w_full_nxt ? S_BURST : S_FILL;
                    w_k_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_k_nxt     = '0;
                w_pass_nxt  = '0;
            end
        endcase
    end

    // MED controls are decoded from the next state so they leave flops aligned with it.
    assign w_shift_nxt = (w_state_nxt == S_BURST) | (w_state_nxt == S_FLUSH);
    assign w_di_nxt    = (w_state_nxt == S_BURST) ? r_buf[w_k_nxt] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_FILL;
            r_cnt     <= '0;
            r_k       <= '0;
            r_pass    <= '0;
            r_med_dsi <= 1'b0;
            r_med_byp <= 1'b0;
            r_med_di  <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_pass    <= w_pass_nxt;
            r_med_dsi <= w_shift_nxt;
            r_med_byp <= w_shift_nxt;
            r_med_di  <= w_di_nxt;
            if (w_burst_end) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_m_data  <= i_med_do;
                r_m_valid <= 1'b1;
            end else if (i_m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_cnt] <= i_s_data;
        end
    end

    assign o_med_di    = r_med_di;
    assign o_med_dsi   = r_med_dsi;
    assign o_med_byp   = r_med_byp;
    assign o_m_data    = r_m_data;
    assign o_m_valid   = r_m_valid;
    assign o_busy      = (r_state != S_FILL);
    assign o_dbg_state = r_state;

endmodule
